activation_ctrl: RTL and testbench

Sequencer for the `activation` datapath. It accepts one configuration per tile (activation type, GELU constants, requant parameters, vector count) and holds that configuration stable on the datapath for the whole tile. It streams `N_PE`-wide vectors through the datapath's 2-stage pipeline, driving `calc_en_i`/`calc_en_q_i` and freezing the pipeline under output backpressure. It sits between the requant output stream and the activation unit inside ITA's feedforward path.

---
 rtl/activation_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_activation_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/activation_ctrl.sv
// -----------------------------------------------------------------------------
// activation_ctrl
//
// Sequencer for the activation datapath. It accepts one configuration per tile
// and holds it stable on the act_* outputs for the whole tile. It streams
// vectors through the datapath's two-stage pipeline and freezes that pipeline
// while the output side applies backpressure.
//
// Optional feature macro: ACTIVATION_CTRL_PERF_EN
//   defined   -> saturating busy-cycle and stall-cycle counters
//   undefined -> stall_cnt_o / active_cnt_o tied to zero, no counter flops
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   cfg_valid_i/cfg_ready_o tile configuration handshake (ready only in IDLE)
//   cfg_activation_i        activation type (0 IDENTITY, 1 GELU, 2 RELU)
//   cfg_len_i               number of vectors in the tile
//   cfg_one/b/c_i           GELU constants
//   cfg_mult/shift/add_i    activation requant parameters
//   in_valid_i/in_ready_o   input vector handshake (data goes to datapath)
//   out_valid_o/out_ready_i output vector handshake (data comes from datapath)
//   act_calc_en_o           datapath stage-1 enable
//   act_calc_en_q_o         datapath stage-2 enable
//   act_*_o                 registered configuration for the datapath
//   busy_o                  controller is not IDLE
//   done_o                  one-cycle pulse at tile end
//   stall_cnt_o             cycles with output stalled (optional)
//   active_cnt_o            cycles with busy_o high (optional)
// -----------------------------------------------------------------------------
module activation_ctrl #(
  parameter int LEN_W  = 16,
  parameter int CNT_W  = 32,
  parameter int ACT_W  = 2,
  parameter int GELU_W = 16,
  parameter int RQC_W  = 8,
  parameter int RQ_W   = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // configuration
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [ACT_W-1:0]  cfg_activation_i,
  input  logic [LEN_W-1:0]  cfg_len_i,
  input  logic [GELU_W-1:0] cfg_one_i,
  input  logic [GELU_W-1:0] cfg_b_i,
  input  logic [GELU_W-1:0] cfg_c_i,
  input  logic [RQC_W-1:0]  cfg_mult_i,
  input  logic [RQC_W-1:0]  cfg_shift_i,
  input  logic [RQ_W-1:0]   cfg_add_i,
  // vector stream
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  // datapath control
  output logic              act_calc_en_o,
  output logic              act_calc_en_q_o,
  output logic [ACT_W-1:0]  act_activation_o,
  output logic [GELU_W-1:0] act_one_o,
  output logic [GELU_W-1:0] act_b_o,
  output logic [GELU_W-1:0] act_c_o,
  output logic [RQC_W-1:0]  act_mult_o,
  output logic [RQC_W-1:0]  act_shift_o,
  output logic [RQ_W-1:0]   act_add_o,
  // status
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  active_cnt_o
);

  localparam logic [ACT_W-1:0] ACT_IDENTITY = ACT_W'(0);
  localparam logic [LEN_W-1:0] LEN_ONE      = LEN_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] w_cnt_inc;
  logic             r_v1;
  logic             r_v2;
  logic             w_v1_nxt;
  logic             w_v2_nxt;
  logic             w_adv;
  logic             w_fire_in;
  logic             w_cfg_fire;
  logic             w_last_accept;

  // Handshake and pipeline-advance decode
  assign w_adv         = !r_v2 || out_ready_i;
  assign in_ready_o    = (r_state == S_RUN) && (r_cnt < r_len) && w_adv;
  assign w_fire_in     = in_valid_i && in_ready_o;
  assign w_cfg_fire    = (r_state == S_IDLE) && cfg_valid_i;
  assign w_cnt_inc     = r_cnt + LEN_ONE;
  // r_cnt < r_len whenever w_fire_in is high, so the increment cannot wrap
  assign w_last_accept = w_fire_in && (w_cnt_inc == r_len);

  assign act_calc_en_o   = w_fire_in;
  assign act_calc_en_q_o = r_v1 && w_adv;
  assign out_valid_o     = r_v2;

  assign cfg_ready_o = (r_state == S_IDLE);
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = (r_state == S_DONE);

  // Next values of the pipeline valid bits (both hold while frozen)
  always_comb begin
    w_v1_nxt = r_v1;
    w_v2_nxt = r_v2;
    if (w_adv) begin
      w_v1_nxt = w_fire_in;
      w_v2_nxt = r_v1;
    end else begin
      w_v1_nxt = r_v1;
      w_v2_nxt = r_v2;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (cfg_valid_i) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last_accept) begin
          w_state_nxt = S_DRAIN;
        end else if (r_cnt == r_len) begin
          // Only reachable for a zero-length tile: nothing to stream or drain
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DRAIN: begin
        // Look at the post-edge pipeline so DONE lands right after the last
        // output handshake instead of one cycle later
        if (!w_v1_nxt && !w_v2_nxt) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pipeline valid bits
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      r_v1 <= w_v1_nxt;
      r_v2 <= w_v2_nxt;
    end
  end

  // Tile length and accepted-vector count
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_len <= '0;
      r_cnt <= '0;
    end else if (w_cfg_fire) begin
      r_len <= cfg_len_i;
      r_cnt <= '0;
    end else if (w_fire_in) begin
      r_cnt <= w_cnt_inc;
    end
  end

  // Configuration registers: loaded only on an IDLE handshake so the datapath
  // never sees a change while vectors are in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      act_activation_o <= ACT_IDENTITY;
      act_one_o        <= '0;
      act_b_o          <= '0;
      act_c_o          <= '0;
      act_mult_o       <= '0;
      act_shift_o      <= '0;
      act_add_o        <= '0;
    end else if (w_cfg_fire) begin
      act_activation_o <= cfg_activation_i;
      act_one_o        <= cfg_one_i;
      act_b_o          <= cfg_b_i;
      act_c_o          <= cfg_c_i;
      act_mult_o       <= cfg_mult_i;
      act_shift_o      <= cfg_shift_i;
      act_add_o        <= cfg_add_i;
    end
  end

`ifdef ACTIVATION_CTRL_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_active_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  // Saturating performance counters, cleared only by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_active_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (busy_o && (r_active_cnt != '1)) begin
        r_active_cnt <= r_active_cnt + CNT_ONE;
      end
      if (r_v2 && !out_ready_i && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
    end
  end

  assign active_cnt_o = r_active_cnt;
  assign stall_cnt_o  = r_stall_cnt;
`else
  assign active_cnt_o = '0;
  assign stall_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_activation_ctrl.sv
// Directed bench for activation_ctrl: a cycle table for a plain GELU tile plus
// hand-written sequences for backpressure, zero-length tiles, ignored
// configuration and mid-tile reset.
module tb_activation_ctrl;

  localparam int LEN_W = 16;
  localparam int CNT_W = 32;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              cfg_valid_i;
  logic              cfg_ready_o;
  logic [1:0]        cfg_activation_i;
  logic [LEN_W-1:0]  cfg_len_i;
  logic [15:0]       cfg_one_i, cfg_b_i, cfg_c_i;
  logic [7:0]        cfg_mult_i, cfg_shift_i, cfg_add_i;
  logic              in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic              act_calc_en_o, act_calc_en_q_o;
  logic [1:0]        act_activation_o;
  logic [15:0]       act_one_o, act_b_o, act_c_o;
  logic [7:0]        act_mult_o, act_shift_o, act_add_o;
  logic              busy_o, done_o;
  logic [CNT_W-1:0]  stall_cnt_o, active_cnt_o;

  activation_ctrl #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_activation_i(cfg_activation_i), .cfg_len_i(cfg_len_i),
    .cfg_one_i(cfg_one_i), .cfg_b_i(cfg_b_i), .cfg_c_i(cfg_c_i),
    .cfg_mult_i(cfg_mult_i), .cfg_shift_i(cfg_shift_i), .cfg_add_i(cfg_add_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .act_calc_en_o(act_calc_en_o), .act_calc_en_q_o(act_calc_en_q_o),
    .act_activation_o(act_activation_o), .act_one_o(act_one_o),
    .act_b_o(act_b_o), .act_c_o(act_c_o), .act_mult_o(act_mult_o),
    .act_shift_o(act_shift_o), .act_add_o(act_add_o),
    .busy_o(busy_o), .done_o(done_o),
    .stall_cnt_o(stall_cnt_o), .active_cnt_o(active_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // inputs {cfg_valid, in_valid, out_ready}; expected flags
  // {cfg_ready, in_ready, out_valid, calc_en, calc_en_q, busy, done}
  typedef struct {
    logic       cfg_v;
    logic       in_v;
    logic       out_r;
    logic [6:0] exp_flags;
    logic       loaded;
  } vec_t;

  vec_t gelu_tab[9];

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [6:0] flags();
    return {cfg_ready_o, in_ready_o, out_valid_o, act_calc_en_o, act_calc_en_q_o, busy_o, done_o};
  endfunction

  function automatic logic [73:0] act_bus();
    return {act_activation_o, act_one_o, act_b_o, act_c_o, act_mult_o, act_shift_o, act_add_o};
  endfunction

  task automatic set_cfg(input logic [1:0] a, input logic [15:0] len, input logic [15:0] one,
                         input logic [15:0] b, input logic [15:0] c, input logic [7:0] m,
                         input logic [7:0] s, input logic [7:0] ad, output logic [73:0] packed_cfg);
    cfg_activation_i = a; cfg_len_i = len; cfg_one_i = one; cfg_b_i = b; cfg_c_i = c;
    cfg_mult_i = m; cfg_shift_i = s; cfg_add_i = ad;
    packed_cfg = {a, one, b, c, m, s, ad};
  endtask

  logic [73:0]      cfg_a, cfg_b;
  logic [CNT_W-1:0] cnt_before;
  int outs, ins, dones;
  logic seen_done, any_done;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    gelu_tab[0] = '{1'b1, 1'b0, 1'b1, 7'b1000000, 1'b0};
    gelu_tab[1] = '{1'b0, 1'b1, 1'b1, 7'b0101010, 1'b1};
    gelu_tab[2] = '{1'b0, 1'b1, 1'b1, 7'b0101110, 1'b1};
    gelu_tab[3] = '{1'b0, 1'b1, 1'b1, 7'b0111110, 1'b1};
    gelu_tab[4] = '{1'b0, 1'b1, 1'b1, 7'b0111110, 1'b1};
    gelu_tab[5] = '{1'b0, 1'b1, 1'b1, 7'b0010110, 1'b1};
    gelu_tab[6] = '{1'b0, 1'b1, 1'b1, 7'b0010010, 1'b1};
    gelu_tab[7] = '{1'b0, 1'b0, 1'b1, 7'b0000011, 1'b1};
    gelu_tab[8] = '{1'b0, 1'b0, 1'b1, 7'b1000000, 1'b1};

    rst_i = 1'b1; cfg_valid_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    set_cfg(2'd0, 16'd0, 16'd0, 16'd0, 16'd0, 8'd0, 8'd0, 8'd0, cfg_a);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i); #1;
    check("reset_flags", 96'(flags()), 96'(7'b1000000));
    check("reset_act", 96'(act_bus()), 96'd0);
    check("reset_cnts", 96'({stall_cnt_o, active_cnt_o}), 96'd0);

    // ---------------- GELU tile, len 4, no backpressure ----------------
    set_cfg(2'd1, 16'd4, 16'h0123, 16'hF00D, 16'h00A5, 8'h5C, 8'h07, 8'hE3, cfg_a);
    cnt_before = active_cnt_o;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk_i);
      cfg_valid_i = gelu_tab[i].cfg_v;
      in_valid_i  = gelu_tab[i].in_v;
      out_ready_i = gelu_tab[i].out_r;
      #1;
      check($sformatf("gelu_flags[%0d]", i), 96'(flags()), 96'(gelu_tab[i].exp_flags));
      check($sformatf("gelu_act[%0d]", i), 96'(act_bus()),
            gelu_tab[i].loaded ? 96'(cfg_a) : 96'd0);
    end
`ifdef ACTIVATION_CTRL_PERF_EN
    check("gelu_active_cnt", 96'(active_cnt_o - cnt_before), 96'd7);
`else
    check("gelu_active_cnt", 96'(active_cnt_o), 96'd0);
`endif

    // ---------------- RELU tile, len 8, 3-cycle stall ----------------
    set_cfg(2'd2, 16'd8, 16'h0011, 16'h0022, 16'h0033, 8'h44, 8'h05, 8'h66, cfg_a);
    cnt_before = stall_cnt_o;
    @(negedge clk_i);
    cfg_valid_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1;
    #1;
    check("relu_cfg_ready", 96'(cfg_ready_o), 96'd1);
    outs = 0; ins = 0; dones = 0; seen_done = 1'b0;
    for (int i = 1; i < 60; i++) begin
      @(negedge clk_i);
      cfg_valid_i = 1'b0; in_valid_i = 1'b1;
      out_ready_i = !(i >= 4 && i <= 6);
      #1;
      if (out_valid_o && out_ready_i) outs++;
      if (in_valid_i && in_ready_o) ins++;
      if (!out_ready_i)
        check($sformatf("relu_stall[%0d]", i),
              96'({in_ready_o, act_calc_en_o, act_calc_en_q_o, out_valid_o}), 96'(4'b0001));
      if (busy_o) check($sformatf("relu_act[%0d]", i), 96'(act_bus()), 96'(cfg_a));
      if (done_o) begin
        dones++;
        seen_done = 1'b1;
        break;
      end
    end
    check("relu_done_seen", 96'(seen_done), 96'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i); in_valid_i = 1'b0; #1;
      if (done_o) dones++;
    end
    check("relu_done_count", 96'(dones), 96'd1);
    check("relu_outs", 96'(outs), 96'd8);
    check("relu_ins", 96'(ins), 96'd8);
`ifdef ACTIVATION_CTRL_PERF_EN
    check("relu_stall_cnt", 96'(stall_cnt_o - cnt_before), 96'd3);
`else
    check("relu_stall_cnt", 96'(stall_cnt_o), 96'd0);
`endif

    // ---------------- zero-length tile ----------------
    set_cfg(2'd1, 16'd0, 16'h0001, 16'h0002, 16'h0003, 8'h04, 8'h05, 8'h06, cfg_a);
    @(negedge clk_i); cfg_valid_i = 1'b1; in_valid_i = 1'b1; out_ready_i = 1'b1; #1;
    check("len0_accept", 96'(flags()), 96'(7'b1000000));
    @(negedge clk_i); cfg_valid_i = 1'b0; #1;
    check("len0_cyc1", 96'(flags()), 96'(7'b0000010));
    @(negedge clk_i); #1;
    check("len0_cyc2_done", 96'(flags()), 96'(7'b0000011));
    @(negedge clk_i); #1;
    check("len0_idle", 96'(flags()), 96'(7'b1000000));
    in_valid_i = 1'b0;

    // ---------------- cfg_valid held during RUN ----------------
    set_cfg(2'd1, 16'd2, 16'hAAAA, 16'hBBBB, 16'hCCCC, 8'h11, 8'h02, 8'h33, cfg_a);
    @(negedge clk_i); cfg_valid_i = 1'b1; in_valid_i = 1'b1; out_ready_i = 1'b1; #1;
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      set_cfg(2'd2, 16'd0, 16'h1234, 16'h5678, 16'h9ABC, 8'h7E, 8'h03, 8'h81, cfg_b);
      #1;
      check($sformatf("hold_act[%0d]", i), 96'(act_bus()), 96'(cfg_a));
      if (done_o) begin
        seen_done = 1'b1;
        break;
      end
    end
    check("hold_done_seen", 96'(seen_done), 96'd1);
    @(negedge clk_i); #1;
    check("hold_idle_act", 96'({cfg_ready_o, act_bus()}), 96'({1'b1, cfg_a}));
    @(negedge clk_i); cfg_valid_i = 1'b0; in_valid_i = 1'b0; #1;
    check("hold_new_act", 96'({busy_o, act_bus()}), 96'({1'b1, cfg_b}));
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i); #1;
      if (done_o) begin
        seen_done = 1'b1;
        break;
      end
    end
    check("hold_b_done", 96'(seen_done), 96'd1);

    // ---------------- reset with two vectors in flight ----------------
    set_cfg(2'd1, 16'd4, 16'h0F0F, 16'h00F0, 16'h0707, 8'h21, 8'h04, 8'h10, cfg_a);
    @(negedge clk_i); cfg_valid_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0; #1;
    @(negedge clk_i); cfg_valid_i = 1'b0; in_valid_i = 1'b1; #1;
    @(negedge clk_i); #1;
    @(negedge clk_i); in_valid_i = 1'b0; #1;
    check("rst_pre_full", 96'({out_valid_o, in_ready_o, busy_o}), 96'(3'b101));
    #1 rst_i = 1'b1;
    #1;
    check("rst_flags", 96'(flags()), 96'(7'b1000000));
    check("rst_act", 96'(act_bus()), 96'd0);
    check("rst_cnts", 96'({stall_cnt_o, active_cnt_o}), 96'd0);
    @(negedge clk_i); rst_i = 1'b0;
    any_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i); #1;
      any_done = any_done | done_o | out_valid_o;
    end
    check("rst_no_done", 96'(any_done), 96'd0);

    set_cfg(2'd0, 16'd2, 16'h0100, 16'h0200, 16'h0300, 8'h01, 8'h01, 8'h01, cfg_a);
    @(negedge clk_i); cfg_valid_i = 1'b1; out_ready_i = 1'b1; #1;
    outs = 0; seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i); cfg_valid_i = 1'b0; in_valid_i = 1'b1; #1;
      if (out_valid_o && out_ready_i) outs++;
      if (done_o) begin
        seen_done = 1'b1;
        break;
      end
    end
    in_valid_i = 1'b0;
    check("post_rst_done", 96'(seen_done), 96'd1);
    check("post_rst_outs", 96'(outs), 96'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
